// File: rtl/phy_freelist_pkg.sv
// phy_freelist_pkg
//   Shared sizing constants, types and pointer helpers for the physical
//   register free list. No ports.
//   Optional feature macro: FREELIST_RECOVERY_EN (used by the interface/top).
package phy_freelist_pkg;

    localparam int PHY_REG_NUM  = 64;
    localparam int PHY_REG_SEL  = $clog2(PHY_REG_NUM);
    localparam int ARCH_REG_NUM = 32;
    localparam int FL_NUM       = PHY_REG_NUM - ARCH_REG_NUM;
    localparam int FL_PTR_SEL   = $clog2(FL_NUM);
    localparam int FL_CNT_SEL   = $clog2(FL_NUM + 1);

    typedef logic [PHY_REG_SEL-1:0] preg_t;
    typedef logic [FL_PTR_SEL-1:0]  fl_ptr_t;
    typedef logic [FL_PTR_SEL:0]    fl_sum_t;
    typedef logic [FL_CNT_SEL-1:0]  fl_cnt_t;

    localparam fl_cnt_t FL_NUM_C = fl_cnt_t'(FL_NUM);

    // Advance a pointer by 0..2 with explicit wrap; depth need not be 2**n.
    function automatic fl_ptr_t fl_wrap(input fl_ptr_t ptr, input logic [1:0] k);
        fl_sum_t sum;
        sum = fl_sum_t'(ptr) + fl_sum_t'(k);
        if (sum >= fl_sum_t'(FL_NUM))
            sum = sum - fl_sum_t'(FL_NUM);
        return sum[FL_PTR_SEL-1:0];
    endfunction

    // Entries from 'from' forward to 'to' in the ring (0 when equal).
    function automatic fl_cnt_t fl_dist(input fl_ptr_t from, input fl_ptr_t to);
        fl_cnt_t d;
        d = fl_cnt_t'(to) - fl_cnt_t'(from);
        if (to < from)
            d = d + FL_NUM_C;
        return d;
    endfunction

endpackage

// File: rtl/phy_freelist_if.sv
// phy_freelist_if
//   Rename/commit bundle between the pipeline (master) and the free list (slave).
//   Rename side : req_1/2 in, phy_dst_1/2, phy_dst_valid_1/2, allocatable out.
//   Commit side : free_en_1/2, free_reg_1/2 in; free_count out.
//   FREELIST_RECOVERY_EN adds prmiss and com_alloc_1/2 (master -> slave).
interface phy_freelist_if;
    import phy_freelist_pkg::*;

    logic    req_1;
    logic    req_2;
    preg_t   phy_dst_1;
    preg_t   phy_dst_2;
    logic    phy_dst_valid_1;
    logic    phy_dst_valid_2;
    logic    allocatable;
    logic    free_en_1;
    logic    free_en_2;
    preg_t   free_reg_1;
    preg_t   free_reg_2;
    fl_cnt_t free_count;
`ifdef FREELIST_RECOVERY_EN
    logic    prmiss;
    logic    com_alloc_1;
    logic    com_alloc_2;

    modport master (
        output req_1, req_2, free_en_1, free_en_2, free_reg_1, free_reg_2,
               prmiss, com_alloc_1, com_alloc_2,
        input  phy_dst_1, phy_dst_2, phy_dst_valid_1, phy_dst_valid_2,
               allocatable, free_count
    );
    modport slave (
        input  req_1, req_2, free_en_1, free_en_2, free_reg_1, free_reg_2,
               prmiss, com_alloc_1, com_alloc_2,
        output phy_dst_1, phy_dst_2, phy_dst_valid_1, phy_dst_valid_2,
               allocatable, free_count
    );
`else
    modport master (
        output req_1, req_2, free_en_1, free_en_2, free_reg_1, free_reg_2,
        input  phy_dst_1, phy_dst_2, phy_dst_valid_1, phy_dst_valid_2,
               allocatable, free_count
    );
    modport slave (
        input  req_1, req_2, free_en_1, free_en_2, free_reg_1, free_reg_2,
        output phy_dst_1, phy_dst_2, phy_dst_valid_1, phy_dst_valid_2,
               allocatable, free_count
    );
`endif

endinterface

// File: rtl/phy_freelist.sv
// phy_freelist
//   Circular free list of physical registers for a 2-wide rename stage.
//   Pops at head on rename (all-or-nothing per group), pushes at tail on commit.
//   Ports: clk, reset (sync, active-high), fl (phy_freelist_if.slave).
//   FREELIST_RECOVERY_EN: keeps a committed head and rewinds to it on prmiss.
module phy_freelist
    import phy_freelist_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    phy_freelist_if.slave fl
);

    preg_t   fl_q [FL_NUM];
    preg_t   fl_d [FL_NUM];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    fl_cnt_t count_q, count_d;
`ifdef FREELIST_RECOVERY_EN
    fl_ptr_t c_head_q, c_head_d;
    logic [1:0] ncom;
`endif

    logic [1:0] nreq;
    logic [1:0] nalloc;
    logic [1:0] nfree;
    logic       grant;
    logic       push_ok;

    // Outputs are combinational from state; slot 2 takes head when slot 1 is idle.
    always_comb begin
        nreq  = {1'b0, fl.req_1} + {1'b0, fl.req_2};
        grant = (count_q >= fl_cnt_t'(nreq));
`ifdef FREELIST_RECOVERY_EN
        grant = grant & ~fl.prmiss;
`endif
        fl.allocatable     = grant;
        fl.phy_dst_valid_1 = fl.req_1 & grant;
        fl.phy_dst_valid_2 = fl.req_2 & grant;
        fl.phy_dst_1       = fl_q[head_q];
        fl.phy_dst_2       = fl.req_1 ? fl_q[fl_wrap(head_q, 2'd1)] : fl_q[head_q];
        fl.free_count      = count_q;
    end

    always_comb begin
        nalloc  = grant ? nreq : 2'd0;
        // A push into a full list is illegal; drop it rather than corrupt the ring.
        push_ok = !((count_q == FL_NUM_C) && (fl.free_en_1 || fl.free_en_2));
        nfree   = push_ok ? ({1'b0, fl.free_en_1} + {1'b0, fl.free_en_2}) : 2'd0;

        fl_d = fl_q;
        if (push_ok) begin
            if (fl.free_en_1)
                fl_d[tail_q] = fl.free_reg_1;
            if (fl.free_en_2)
                fl_d[fl_wrap(tail_q, {1'b0, fl.free_en_1})] = fl.free_reg_2;
        end

        tail_d  = fl_wrap(tail_q, nfree);
        head_d  = fl_wrap(head_q, nalloc);
        count_d = count_q - fl_cnt_t'(nalloc) + fl_cnt_t'(nfree);

`ifdef FREELIST_RECOVERY_EN
        ncom     = {1'b0, fl.com_alloc_1} + {1'b0, fl.com_alloc_2};
        c_head_d = fl_wrap(c_head_q, ncom);
        // Rewind: everything from the committed head up to the new tail is free again.
        if (fl.prmiss) begin
            head_d  = c_head_d;
            count_d = FL_NUM_C - fl_dist(tail_d, c_head_d);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FL_NUM; i++)
                fl_q[i] <= preg_t'(ARCH_REG_NUM + i);
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= FL_NUM_C;
`ifdef FREELIST_RECOVERY_EN
            c_head_q <= '0;
`endif
        end else begin
            fl_q     <= fl_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
`ifdef FREELIST_RECOVERY_EN
            c_head_q <= c_head_d;
`endif
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !((count_q == FL_NUM_C) && (fl.free_en_1 || fl.free_en_2)));

endmodule

// File: tb/tb_phy_freelist.sv
// tb_phy_freelist
//   Self-checking bench for phy_freelist. The reference model is a queue of
//   free register numbers (plus a queue of speculative allocations when
//   FREELIST_RECOVERY_EN is defined).
module tb_phy_freelist;
    import phy_freelist_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    phy_freelist_if fl();

    phy_freelist dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl)
    );

    int errors = 0;
    int checks = 0;

    int free_q[$];
    int spec_q[$];
    int cu;  // committed allocations whose stale register is not yet freed

    task automatic model_reset();
        free_q.delete();
        for (int i = 0; i < FL_NUM; i++) free_q.push_back(ARCH_REG_NUM + i);
        spec_q.delete();
        cu = 0;
    endtask

    task automatic drive(input logic r1, input logic r2,
                         input logic f1, input int fr1,
                         input logic f2, input int fr2);
        fl.req_1      = r1;
        fl.req_2      = r2;
        fl.free_en_1  = f1;
        fl.free_reg_1 = preg_t'(fr1);
        fl.free_en_2  = f2;
        fl.free_reg_2 = preg_t'(fr2);
`ifdef FREELIST_RECOVERY_EN
        fl.prmiss      = 1'b0;
        fl.com_alloc_1 = 1'b0;
        fl.com_alloc_2 = 1'b0;
`endif
    endtask

    function automatic bit exp_alloc();
        int n;
        bit pm;
        n  = int'(fl.req_1) + int'(fl.req_2);
        pm = 1'b0;
`ifdef FREELIST_RECOVERY_EN
        pm = fl.prmiss;
`endif
        return (free_q.size() >= n) && !pm;
    endfunction

    // Apply the current inputs to the model, then take the clock edge.
    task automatic tick();
        bit ok;
        int ncom;
        int nfree;
        int a;
        ok    = exp_alloc();
        ncom  = 0;
        nfree = int'(fl.free_en_1) + int'(fl.free_en_2);
`ifdef FREELIST_RECOVERY_EN
        ncom = int'(fl.com_alloc_1) + int'(fl.com_alloc_2);
        repeat (ncom) void'(spec_q.pop_front());
`endif
        if (ok) begin
            if (fl.req_1) begin a = free_q.pop_front(); spec_q.push_back(a); end
            if (fl.req_2) begin a = free_q.pop_front(); spec_q.push_back(a); end
        end
`ifndef FREELIST_RECOVERY_EN
        spec_q.delete();
`endif
        if (fl.free_en_1) free_q.push_back(int'(fl.free_reg_1));
        if (fl.free_en_2) free_q.push_back(int'(fl.free_reg_2));
        cu = cu + ncom - nfree;
`ifdef FREELIST_RECOVERY_EN
        if (fl.prmiss) begin
            free_q = {spec_q, free_q};
            spec_q.delete();
        end
`endif
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 63)),
              1'($urandom), int'($urandom_range(0, 63)));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (fl.free_count !== FL_NUM_C) begin errors++; $display("FAIL reset_count: got %0d expected %0d", fl.free_count, FL_NUM); end
        checks++; if (fl.phy_dst_1 !== preg_t'(32)) begin errors++; $display("FAIL reset_dst1: got %0d expected 32", fl.phy_dst_1); end
        checks++; if (fl.allocatable !== 1'b1) begin errors++; $display("FAIL reset_alloc_idle: got %0d expected 1", fl.allocatable); end
        // Disturb state, then reset mid-operation.
        repeat (3) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        do_reset();
        fl.req_1 = 1'b1;
        #1;
        checks++; if (fl.free_count !== FL_NUM_C) begin errors++; $display("FAIL rereset_count: got %0d expected %0d", fl.free_count, FL_NUM); end
        checks++; if (fl.phy_dst_1 !== preg_t'(32)) begin errors++; $display("FAIL rereset_dst1: got %0d expected 32", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(33)) begin errors++; $display("FAIL rereset_dst2: got %0d expected 33", fl.phy_dst_2); end
    endtask

    task automatic test_pair_alloc();
        do_reset();
        drive(1, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(32)) begin errors++; $display("FAIL pair_dst1: got %0d expected 32", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(33)) begin errors++; $display("FAIL pair_dst2: got %0d expected 33", fl.phy_dst_2); end
        checks++; if ({fl.phy_dst_valid_1, fl.phy_dst_valid_2} !== 2'b11) begin errors++; $display("FAIL pair_valids: got %b expected 11", {fl.phy_dst_valid_1, fl.phy_dst_valid_2}); end
        tick();
        @(negedge clk);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(34)) begin errors++; $display("FAIL pair2_dst1: got %0d expected 34", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(35)) begin errors++; $display("FAIL pair2_dst2: got %0d expected 35", fl.phy_dst_2); end
        checks++; if (fl.free_count !== fl_cnt_t'(30)) begin errors++; $display("FAIL pair_count: got %0d expected 30", fl.free_count); end
        tick();
    endtask

    task automatic test_slot2_only();
        do_reset();
        drive(0, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.phy_dst_2 !== preg_t'(32)) begin errors++; $display("FAIL slot2_dst2: got %0d expected 32", fl.phy_dst_2); end
        checks++; if ({fl.phy_dst_valid_1, fl.phy_dst_valid_2} !== 2'b01) begin errors++; $display("FAIL slot2_valids: got %b expected 01", {fl.phy_dst_valid_1, fl.phy_dst_valid_2}); end
        tick();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(33)) begin errors++; $display("FAIL slot2_next: got %0d expected 33", fl.phy_dst_1); end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        repeat (15) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.allocatable !== 1'b0) begin errors++; $display("FAIL stall_alloc: got %0d expected 0", fl.allocatable); end
        checks++; if ({fl.phy_dst_valid_1, fl.phy_dst_valid_2} !== 2'b00) begin errors++; $display("FAIL stall_valids: got %b expected 00", {fl.phy_dst_valid_1, fl.phy_dst_valid_2}); end
        tick();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        #1;
        checks++; if (fl.free_count !== fl_cnt_t'(1)) begin errors++; $display("FAIL stall_count: got %0d expected 1", fl.free_count); end
        checks++; if (fl.phy_dst_valid_1 !== 1'b1) begin errors++; $display("FAIL last_valid1: got %0d expected 1", fl.phy_dst_valid_1); end
        checks++; if (fl.phy_dst_1 !== preg_t'(63)) begin errors++; $display("FAIL last_dst1: got %0d expected 63", fl.phy_dst_1); end
        tick();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (fl.free_count !== fl_cnt_t'(0)) begin errors++; $display("FAIL empty_count: got %0d expected 0", fl.free_count); end
        checks++; if (fl.allocatable !== 1'b1) begin errors++; $display("FAIL empty_noreq_alloc: got %0d expected 1", fl.allocatable); end
    endtask

    // Continues from the empty list left by test_stall.
    task automatic test_empty_refill();
        drive(1, 0, 1, 7, 1, 9);
        #1;
        checks++; if (fl.allocatable !== 1'b0) begin errors++; $display("FAIL refill_same_alloc: got %0d expected 0", fl.allocatable); end
        checks++; if (fl.phy_dst_valid_1 !== 1'b0) begin errors++; $display("FAIL refill_same_valid1: got %0d expected 0", fl.phy_dst_valid_1); end
        tick();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(7)) begin errors++; $display("FAIL refill_dst1: got %0d expected 7", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(9)) begin errors++; $display("FAIL refill_dst2: got %0d expected 9", fl.phy_dst_2); end
        checks++; if ({fl.phy_dst_valid_1, fl.phy_dst_valid_2} !== 2'b11) begin errors++; $display("FAIL refill_valids: got %b expected 11", {fl.phy_dst_valid_1, fl.phy_dst_valid_2}); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            drive(1, 0, 1, i + 1, 0, 0);
            tick();
        end
        // Head is at the last slot, tail one behind it: both pointers wrap now.
        @(negedge clk);
        drive(1, 1, 1, 50, 1, 51);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(63)) begin errors++; $display("FAIL wrap_dst1: got %0d expected 63", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(1)) begin errors++; $display("FAIL wrap_dst2: got %0d expected 1", fl.phy_dst_2); end
        checks++; if (fl.free_count !== fl_cnt_t'(31)) begin errors++; $display("FAIL wrap_count_before: got %0d expected 31", fl.free_count); end
        tick();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(2)) begin errors++; $display("FAIL wrap_next_dst1: got %0d expected 2", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(3)) begin errors++; $display("FAIL wrap_next_dst2: got %0d expected 3", fl.phy_dst_2); end
        checks++; if (fl.free_count !== fl_cnt_t'(31)) begin errors++; $display("FAIL wrap_count_after: got %0d expected 31", fl.free_count); end
        tick();
    endtask

`ifdef FREELIST_RECOVERY_EN
    task automatic test_recovery();
        do_reset();
        repeat (2) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        // Oldest allocation (32) commits and frees reg 5 while the rest is squashed.
        @(negedge clk);
        drive(1, 1, 1, 5, 0, 0);
        fl.com_alloc_1 = 1'b1;
        fl.prmiss      = 1'b1;
        #1;
        checks++; if (fl.allocatable !== 1'b0) begin errors++; $display("FAIL prmiss_alloc: got %0d expected 0", fl.allocatable); end
        checks++; if ({fl.phy_dst_valid_1, fl.phy_dst_valid_2} !== 2'b00) begin errors++; $display("FAIL prmiss_valids: got %b expected 00", {fl.phy_dst_valid_1, fl.phy_dst_valid_2}); end
        tick();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.phy_dst_1 !== preg_t'(33)) begin errors++; $display("FAIL recov_dst1: got %0d expected 33", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(34)) begin errors++; $display("FAIL recov_dst2: got %0d expected 34", fl.phy_dst_2); end
        checks++; if (fl.free_count !== fl_cnt_t'(32)) begin errors++; $display("FAIL recov_count: got %0d expected 32", fl.free_count); end
        // Reset in the cycle right after the rewind.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive(1, 1, 0, 0, 0, 0);
        #1;
        checks++; if (fl.free_count !== FL_NUM_C) begin errors++; $display("FAIL recov_reset_count: got %0d expected %0d", fl.free_count, FL_NUM); end
        checks++; if (fl.phy_dst_1 !== preg_t'(32)) begin errors++; $display("FAIL recov_reset_dst1: got %0d expected 32", fl.phy_dst_1); end
        checks++; if (fl.phy_dst_2 !== preg_t'(33)) begin errors++; $display("FAIL recov_reset_dst2: got %0d expected 33", fl.phy_dst_2); end
        tick();
    endtask
`endif

    task automatic test_random();
        int nreq, nalloc, maxf, nf, maxc, nc, sel;
        bit ok;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 0, 0, 0, 0);
            nreq = int'(fl.req_1) + int'(fl.req_2);
`ifdef FREELIST_RECOVERY_EN
            fl.prmiss = ($urandom_range(0, 15) == 0);
            maxc = (spec_q.size() < 2) ? spec_q.size() : 2;
            nc   = int'($urandom_range(0, maxc));
            sel  = int'($urandom_range(0, 1));
            fl.com_alloc_1 = (nc == 2) || (nc == 1 && sel == 0);
            fl.com_alloc_2 = (nc == 2) || (nc == 1 && sel == 1);
            maxf = cu + nc;
`else
            maxc = 0; nc = 0;
            ok     = (free_q.size() >= nreq);
            nalloc = ok ? nreq : 0;
            maxf   = (free_q.size() == FL_NUM) ? 0 : FL_NUM - free_q.size() + nalloc;
`endif
            if (maxf > 2) maxf = 2;
            nf  = int'($urandom_range(0, maxf));
            sel = int'($urandom_range(0, 1));
            fl.free_en_1  = (nf == 2) || (nf == 1 && sel == 0);
            fl.free_en_2  = (nf == 2) || (nf == 1 && sel == 1);
            fl.free_reg_1 = preg_t'($urandom_range(0, 63));
            fl.free_reg_2 = preg_t'($urandom_range(0, 63));
            #1;
            ok = exp_alloc();
            checks++; if (fl.allocatable !== ok) begin errors++; $display("FAIL rnd_alloc cyc %0d: got %0d expected %0d", cyc, fl.allocatable, ok); end
            checks++; if (fl.phy_dst_valid_1 !== (fl.req_1 & ok)) begin errors++; $display("FAIL rnd_valid1 cyc %0d: got %0d expected %0d", cyc, fl.phy_dst_valid_1, fl.req_1 & ok); end
            checks++; if (fl.phy_dst_valid_2 !== (fl.req_2 & ok)) begin errors++; $display("FAIL rnd_valid2 cyc %0d: got %0d expected %0d", cyc, fl.phy_dst_valid_2, fl.req_2 & ok); end
            checks++; if (fl.free_count !== fl_cnt_t'(free_q.size())) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, fl.free_count, free_q.size()); end
            if (ok && fl.req_1) begin
                checks++; if (fl.phy_dst_1 !== preg_t'(free_q[0])) begin errors++; $display("FAIL rnd_dst1 cyc %0d: got %0d expected %0d", cyc, fl.phy_dst_1, free_q[0]); end
            end
            if (ok && fl.req_2) begin
                checks++; if (fl.phy_dst_2 !== preg_t'(fl.req_1 ? free_q[1] : free_q[0])) begin errors++; $display("FAIL rnd_dst2 cyc %0d: got %0d expected %0d", cyc, fl.phy_dst_2, fl.req_1 ? free_q[1] : free_q[0]); end
            end
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_pair_alloc();
        test_slot2_only();
        test_stall();
        test_empty_refill();
        test_wrap();
`ifdef FREELIST_RECOVERY_EN
        test_recovery();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
